ram_write_arbiter: RTL and testbench

- Shares the single data-RAM write port between the core writeback path and a host/debug loader.
- Core writes have priority and pass through with zero latency.
- Host writes are buffered in a one-entry holding register and issued in idle write slots.
- If the host waits too long, the block stalls the core for one cycle to force the host write through.
- Sits between the core's result/write-enable logic and the dual-read-port RAM write inputs.

---
 rtl/ram_write_arbiter.sv | 126 ++++++++++++
 tb/tb_ram_write_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_write_arbiter
// Purpose  : Shares the single data-RAM write port between the core
//            writeback path (priority, zero latency) and a host/debug loader
//            (one-entry holding register, issued in idle write slots). A host
//            write that has been blocked for MAX_WAIT cycles gets a forced
//            one-cycle core stall slot.
// Ports    : Clock, Reset            - clock, synchronous active-high reset
//            iCoreWriteEnable/Address/DataIn - core write request
//            iHostReq/Address/Data   - host write request (level, held to ack)
//            oHostAck                - one-cycle pulse, host write committed
//            oCoreStall              - core must not commit this cycle
//            oWriteEnable/Address/DataIn - RAM write port
//            oStallCount             - forced stall slot count
// Options  : ARB_STALL_COUNT_EN - build the saturating stall slot counter;
//            when undefined oStallCount is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module ram_write_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              iCoreWriteEnable,
    input  logic [ADDR_W-1:0] iCoreWriteAddress,
    input  logic [DATA_W-1:0] iCoreDataIn,
    input  logic              iHostReq,
    input  logic [ADDR_W-1:0] iHostAddress,
    input  logic [DATA_W-1:0] iHostData,
    output logic              oHostAck,
    output logic              oCoreStall,
    output logic              oWriteEnable,
    output logic [ADDR_W-1:0] oWriteAddress,
    output logic [DATA_W-1:0] oDataIn,
    output logic [15:0]       oStallCount
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PENDING = 3'd1,
        ST_STALL   = 3'd2,
        ST_ACK     = 3'd3,
        ST_WAITLOW = 3'd4
    } state_t;

    localparam logic [7:0] c_MAX_WAIT = 8'(MAX_WAIT);

    state_t            r_state;
    state_t            w_nextState;
    logic [ADDR_W-1:0] r_holdAddr;
    logic [DATA_W-1:0] r_holdData;
    logic [7:0]        r_waitCount;
    logic [7:0]        w_waitNext;
    logic              w_hostGrant;

    assign w_waitNext = r_waitCount + 8'd1;

    // Next-state logic
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE:    if (iHostReq) w_nextState = ST_PENDING;
            ST_PENDING: begin
                if (!iCoreWriteEnable)
                    w_nextState = ST_ACK;
                else if (w_waitNext == c_MAX_WAIT)
                    w_nextState = ST_STALL;
            end
            ST_STALL:   w_nextState = ST_ACK;
            ST_ACK:     w_nextState = ST_WAITLOW;
            ST_WAITLOW: if (!iHostReq) w_nextState = ST_IDLE;
            default:    w_nextState = ST_IDLE;
        endcase
    end

    // State, holding register and wait counter
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state     <= ST_IDLE;
            r_holdAddr  <= '0;
            r_holdData  <= '0;
            r_waitCount <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == ST_IDLE && iHostReq) begin
                r_holdAddr  <= iHostAddress;
                r_holdData  <= iHostData;
                r_waitCount <= '0;
            end else if (r_state == ST_PENDING && iCoreWriteEnable) begin
                r_waitCount <= w_waitNext;
            end
        end
    end

    // Host-side outputs are masked while Reset is high so a buffered host
    // write caught by reset never reaches the RAM and is never acknowledged.
    assign w_hostGrant = !Reset && ((r_state == ST_STALL) ||
                                    (r_state == ST_PENDING && !iCoreWriteEnable));

    assign oWriteEnable  = w_hostGrant ? 1'b1       : iCoreWriteEnable;
    assign oWriteAddress = w_hostGrant ? r_holdAddr : iCoreWriteAddress;
    assign oDataIn       = w_hostGrant ? r_holdData : iCoreDataIn;
    assign oCoreStall    = !Reset && (r_state == ST_STALL);
    assign oHostAck      = !Reset && (r_state == ST_ACK);

`ifdef ARB_STALL_COUNT_EN
    logic [15:0] r_stallCount;

    // Saturating count of forced stall slots
    always_ff @(posedge Clock) begin
        if (Reset)
            r_stallCount <= '0;
        else if (r_state == ST_STALL && r_stallCount != 16'hFFFF)
            r_stallCount <= r_stallCount + 16'd1;
    end

    assign oStallCount = r_stallCount;
`else
    assign oStallCount = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_write_arbiter
// Purpose  : Self-checking bench for ram_write_arbiter. A transaction-level
//            reference model predicts every RAM write (with its cycle and
//            stall flag) and every host ack cycle into queues; a monitor pops
//            and compares whenever the DUT writes or acks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_write_arbiter;

    localparam int MAX_WAIT = 8;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        cwe = 1'b0;
    logic [7:0]  caddr = '0;
    logic [15:0] cdata = '0;
    logic        hreq = 1'b0;
    logic [7:0]  haddr = '0;
    logic [15:0] hdata = '0;
    logic        oHostAck, oCoreStall, oWriteEnable;
    logic [7:0]  oWriteAddress;
    logic [15:0] oDataIn, oStallCount;

    ram_write_arbiter #(.ADDR_W(8), .DATA_W(16), .MAX_WAIT(MAX_WAIT)) dut (
        .Clock(Clock), .Reset(Reset),
        .iCoreWriteEnable(cwe), .iCoreWriteAddress(caddr), .iCoreDataIn(cdata),
        .iHostReq(hreq), .iHostAddress(haddr), .iHostData(hdata),
        .oHostAck(oHostAck), .oCoreStall(oCoreStall),
        .oWriteEnable(oWriteEnable), .oWriteAddress(oWriteAddress),
        .oDataIn(oDataIn), .oStallCount(oStallCount)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        bit          stall;
        logic [7:0]  addr;
        logic [15:0] data;
        int          cyc;
    } wr_t;

    wr_t         wrQ[$];
    int          ackQ[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    logic [15:0] ramDut [0:255];

    // Reference model: host transaction timeline in absolute cycle numbers
    bit          mPending = 0;   // host write accepted, not yet written
    bit          mNeedLow = 0;   // written, host must drop iHostReq first
    int          mDeadline = -1; // cycle of the forced stall slot
    int          mAckCyc = -1;   // cycle the ack must appear
    logic [7:0]  mAddr;
    logic [15:0] mData;
    int          expStall = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic pushWr(input bit st, input logic [7:0] a, input logic [15:0] d);
        wr_t e;
        e.stall = st; e.addr = a; e.data = d; e.cyc = cyc;
        wrQ.push_back(e);
    endtask

    // One clock cycle: drive inputs after the edge, then predict this cycle.
    task automatic step(input logic we, input logic [7:0] ca, input logic [15:0] cd,
                        input logic hr, input logic [7:0] ha, input logic [15:0] hd,
                        input logic rs);
        @(posedge Clock);
        #1;
        cyc++;
        cwe = we; caddr = ca; cdata = cd;
        hreq = hr; haddr = ha; hdata = hd;
        Reset = rs;
        if (rs) begin
            if (we) pushWr(1'b0, ca, cd);
            mPending = 0; mNeedLow = 0; mAckCyc = -1; mDeadline = -1; expStall = 0;
        end else begin
            if (cyc == mAckCyc) ackQ.push_back(cyc);
            if (mPending && (cyc == mDeadline || !we)) begin
                pushWr(cyc == mDeadline, mAddr, mData);
                if (cyc == mDeadline) expStall++;
                mPending = 0;
                mNeedLow = 1;
                mAckCyc  = cyc + 1;
            end else begin
                if (we) pushWr(1'b0, ca, cd);
                if (cyc == mAckCyc) begin
                    // ack cycle: host request level is not looked at
                end else if (mNeedLow) begin
                    if (!hr) mNeedLow = 0;
                end else if (!mPending && hr) begin
                    mPending  = 1;
                    mAddr     = ha;
                    mData     = hd;
                    mDeadline = cyc + MAX_WAIT + 1;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0);
    endtask

    function automatic logic [15:0] expStallCount();
`ifdef ARB_STALL_COUNT_EN
        return 16'(expStall);
`else
        return 16'h0000;
`endif
    endfunction

    // Monitor / scoreboard
    always @(negedge Clock) begin
        if (oWriteEnable) begin
            tests++;
            if (wrQ.size() == 0) begin
                fails++;
                $display("FAIL write_unexpected: got addr %h data %h at cycle %0d, required none",
                         oWriteAddress, oDataIn, cyc);
            end else begin
                wr_t e;
                e = wrQ.pop_front();
                if (e.cyc != cyc || e.addr !== oWriteAddress || e.data !== oDataIn ||
                    e.stall !== oCoreStall) begin
                    fails++;
                    $display("FAIL write: got cyc %0d addr %h data %h stall %b, required cyc %0d addr %h data %h stall %b",
                             cyc, oWriteAddress, oDataIn, oCoreStall, e.cyc, e.addr, e.data, e.stall);
                end
            end
            ramDut[oWriteAddress] = oDataIn;
        end
        if (oHostAck) begin
            tests++;
            if (ackQ.size() == 0) begin
                fails++;
                $display("FAIL ack_unexpected: got ack at cycle %0d, required none", cyc);
            end else begin
                int a;
                a = ackQ.pop_front();
                if (a != cyc) begin
                    fails++;
                    $display("FAIL ack: got cycle %0d required cycle %0d", cyc, a);
                end
            end
        end
        if (oCoreStall && !oWriteEnable) begin
            tests++;
            fails++;
            $display("FAIL stall_without_write: got stall 1 write 0, required no stall, cycle %0d", cyc);
        end
    end

    initial begin
        bit          hostOn;
        bit          hostAcked;
        logic [7:0]  ha;
        logic [15:0] hd;
        for (int i = 0; i < 256; i++) ramDut[i] = 16'h0000;

        // Reset and reset-state checks
        step(1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1);
        step(1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1);
        idle(1);
        @(negedge Clock);
        chk("reset_we", 32'(oWriteEnable), 32'd0);
        chk("reset_ack", 32'(oHostAck), 32'd0);
        chk("reset_stall", 32'(oCoreStall), 32'd0);
        chk("reset_stallcnt", 32'(oStallCount), 32'd0);

        // Core pass-through, zero latency
        step(1'b1, 8'h05, 16'h1234, 1'b0, 8'h00, 16'h0000, 1'b0);
        @(negedge Clock);
        chk("core_we", 32'(oWriteEnable), 32'd1);
        chk("core_addr", 32'(oWriteAddress), 32'h05);
        chk("core_data", 32'(oDataIn), 32'h1234);
        chk("core_stall", 32'(oCoreStall), 32'd0);

        // Host write with core idle
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 16'h0000, 1'b1, 8'h10, 16'hBEEF, 1'b0);
        idle(2);
        @(negedge Clock);
        chk("ram_host_beef", 32'(ramDut[8'h10]), 32'hBEEF);

        // Host blocked by continuous core writes: forced stall slot
        for (int i = 0; i < 12; i++)
            step(1'b1, 8'(8'h60 + i), 16'(16'hA000 + i), 1'b1, 8'h20, 16'hCAFE, 1'b0);
        idle(2);
        @(negedge Clock);
        chk("ram_host_cafe", 32'(ramDut[8'h20]), 32'hCAFE);
        chk("stallcnt_after_stall", 32'(oStallCount), 32'(expStallCount()));

        // Host holds request past ack, then a fresh request
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 16'h0000, 1'b1, 8'h30, 16'h3030, 1'b0);
        idle(1);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 16'h0000, 1'b1, 8'h31, 16'h3131, 1'b0);
        idle(2);
        @(negedge Clock);
        chk("ram_host_31", 32'(ramDut[8'h31]), 32'h3131);

        // Reset while PENDING discards the host write
        step(1'b0, 8'h00, 16'h0000, 1'b1, 8'h40, 16'h4444, 1'b0);
        step(1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1);
        idle(1);
        @(negedge Clock);
        chk("rstpend_we", 32'(oWriteEnable), 32'd0);
        chk("rstpend_ack", 32'(oHostAck), 32'd0);
        chk("rstpend_stallcnt", 32'(oStallCount), 32'd0);
        chk("rstpend_ram", 32'(ramDut[8'h40]), 32'h0000);

        // Same-address collision: core first, host later wins
        for (int i = 0; i < 3; i++) step(1'b1, 8'h10, 16'h1111, 1'b1, 8'h10, 16'h2222, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 16'h0000, 1'b1, 8'h10, 16'h2222, 1'b0);
        idle(2);
        @(negedge Clock);
        chk("ram_collision", 32'(ramDut[8'h10]), 32'h2222);

        // Randomized traffic with a protocol-following host
        hostOn = 0; hostAcked = 0; ha = '0; hd = '0;
        for (int i = 0; i < 3000; i++) begin
            logic we;
            logic rs;
            we = ($urandom_range(0, 99) < 75);
            rs = ($urandom_range(0, 399) == 0);
            if (!hostOn && $urandom_range(0, 99) < 20) begin
                hostOn = 1; hostAcked = 0;
                ha = 8'($urandom); hd = 16'($urandom);
            end else if (hostOn && hostAcked && $urandom_range(0, 99) < 40) begin
                hostOn = 0; hostAcked = 0;
            end
            step(we, 8'($urandom), 16'($urandom), hostOn, ha, hd, rs);
            if (cyc == mAckCyc && !rs) hostAcked = 1;
        end
        // Drain: let any outstanding host request finish, then release it
        for (int i = 0; i < 3 * MAX_WAIT && hostOn && !hostAcked; i++) begin
            step(1'b0, 8'h00, 16'h0000, 1'b1, ha, hd, 1'b0);
            if (cyc == mAckCyc) hostAcked = 1;
        end
        idle(4);
        @(negedge Clock);
        chk("final_wrq_empty", 32'(wrQ.size()), 32'd0);
        chk("final_ackq_empty", 32'(ackQ.size()), 32'd0);
        chk("final_stallcnt", 32'(oStallCount), 32'(expStallCount()));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
